// File: rtl/dpwm_flags_mc.sv
// Multi-channel dual-edge period counter for the DPWM: counts both clk_base edges per channel,
// restarts on each L_DPWM falling edge and captures the finished period behind a valid/ack handshake.
// Build option FLAGS_SATURATE_EN: counters saturate instead of wrapping.
module dpwm_flags_mc #(
    parameter int CH        = 4,
    parameter int DE_BITS   = 6,
    parameter int DC_LENGTH = 13
) (
    input  logic                                   clk_base,
    input  logic                                   reset_Flags,
    input  logic                                   en,
    input  logic [CH-1:0]                          l_dpwm,
    output logic [CH*(DC_LENGTH-DE_BITS+3)-1:0]    flags_out,
    output logic [CH*(DC_LENGTH-DE_BITS+3)-1:0]    cap_data,
    output logic [CH-1:0]                          cap_valid,
    input  logic [CH-1:0]                          cap_ack,
    output logic [CH-1:0]                          cap_overrun
);
    localparam int CNT_W = DC_LENGTH - DE_BITS;
    localparam int CW    = CNT_W + 2;
    localparam int OW    = CNT_W + 3;
    localparam logic [CW-1:0] C_MAX = '1;

    function automatic logic [CW-1:0] f_inc(input logic [CW-1:0] v);
`ifdef FLAGS_SATURATE_EN
        f_inc = (v == C_MAX) ? v : v + CW'(1);
`else
        f_inc = v + CW'(1);
`endif
    endfunction

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic          r_l_d;
        logic          r_rst_n_pend;
        logic          r_cap_valid;
        logic          r_cap_overrun;
        logic [CW-1:0] r_cnt_p;
        logic [CW-1:0] r_cnt_n;
        logic [OW-1:0] r_cap_data;
        logic [OW-1:0] w_sum;
        logic          w_fall;

        assign w_sum  = {1'b0, r_cnt_p} + {1'b0, r_cnt_n};
        assign w_fall = r_l_d & ~l_dpwm[k];

        always_ff @(posedge clk_base or posedge reset_Flags) begin
            if (reset_Flags) begin
                r_l_d         <= 1'b0;
                r_rst_n_pend  <= 1'b0;
                r_cnt_p       <= '0;
                r_cap_data    <= '0;
                r_cap_valid   <= 1'b0;
                r_cap_overrun <= 1'b0;
            end else begin
                r_l_d        <= l_dpwm[k];
                r_rst_n_pend <= w_fall;
                if (w_fall)
                    r_cnt_p <= '0;
                else if (en)
                    r_cnt_p <= f_inc(r_cnt_p);
                if (w_fall) begin
                    r_cap_data  <= w_sum;
                    r_cap_valid <= 1'b1;
                    if (r_cap_valid && !cap_ack[k])
                        r_cap_overrun <= 1'b1;
                end else if (cap_ack[k]) begin
                    r_cap_valid <= 1'b0;
                end
            end
        end

        // The negedge half of the restart is requested from the posedge domain,
        // so l_dpwm never reaches a counter through an asynchronous path.
        always_ff @(negedge clk_base or posedge reset_Flags) begin
            if (reset_Flags)
                r_cnt_n <= '0;
            else if (r_rst_n_pend)
                r_cnt_n <= '0;
            else if (en)
                r_cnt_n <= f_inc(r_cnt_n);
        end

        assign flags_out[k*OW +: OW] = w_sum;
        assign cap_data[k*OW +: OW]  = r_cap_data;
        assign cap_valid[k]          = r_cap_valid;
        assign cap_overrun[k]        = r_cap_overrun;
    end
endmodule

// File: tb/tb_dpwm_flags_mc.sv
// Bench for dpwm_flags_mc: directed stimulus pushes expected captures into a queue,
// a monitor pops and compares whenever a channel presents a new capture.
module tb_dpwm_flags_mc;
    localparam int CH = 4;
    localparam int OW = 10;

    logic              clk_base = 1'b0;
    logic              reset_Flags = 1'b0;
    logic              en = 1'b0;
    logic [CH-1:0]     l_dpwm = '1;
    logic [CH-1:0]     cap_ack = '0;
    logic [CH*OW-1:0]  flags_out;
    logic [CH*OW-1:0]  cap_data;
    logic [CH-1:0]     cap_valid;
    logic [CH-1:0]     cap_overrun;

    typedef struct {
        int ch;
        int data;
        bit ovr;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    dpwm_flags_mc dut (
        .clk_base    (clk_base),
        .reset_Flags (reset_Flags),
        .en          (en),
        .l_dpwm      (l_dpwm),
        .flags_out   (flags_out),
        .cap_data    (cap_data),
        .cap_valid   (cap_valid),
        .cap_ack     (cap_ack),
        .cap_overrun (cap_overrun)
    );

    always #5 clk_base = ~clk_base;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int fl(input int ch);
        return {22'd0, flags_out[ch*OW +: OW]};
    endfunction

    function automatic int cd(input int ch);
        return {22'd0, cap_data[ch*OW +: OW]};
    endfunction

    task automatic push(input int ch, input int d, input bit o);
        exp_t e;
        e.ch = ch; e.data = d; e.ovr = o;
        sb_q.push_back(e);
    endtask

    task automatic pos();
        @(posedge clk_base);
        #1;
        cyc++;
    endtask

    task automatic neg();
        @(negedge clk_base);
        #1;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) pos();
    endtask

    task automatic do_reset();
        reset_Flags = 1'b1;
        #1;
        for (int k = 0; k < CH; k++) begin
            chk("rst_flags", fl(k), 0);
            chk("rst_cap_data", cd(k), 0);
            chk("rst_cap_valid", int'(cap_valid[k]), 0);
            chk("rst_cap_overrun", int'(cap_overrun[k]), 0);
        end
        neg();
        reset_Flags = 1'b0;
        cyc = 0;
    endtask

    // Monitor: a capture is visible as a valid rise, new data while valid, or an overrun rise.
    initial begin
        logic [CH-1:0] pv;
        logic [CH-1:0] po;
        logic [OW-1:0] pd [CH];
        logic [OW-1:0] d;
        exp_t          e;
        pv = '0;
        po = '0;
        for (int k = 0; k < CH; k++) pd[k] = '0;
        forever begin
            @(posedge clk_base);
            #2;
            for (int k = 0; k < CH; k++) begin
                d = cap_data[k*OW +: OW];
                if ((cap_valid[k] && !pv[k]) || (cap_valid[k] && d != pd[k]) ||
                    (cap_overrun[k] && !po[k])) begin
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_unexpected: ch%0d got data %0d expected no capture", k, d);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_ch", k, e.ch);
                        chk("sb_data", {22'd0, d}, e.data);
                        chk("sb_ovr", int'(cap_overrun[k]), int'(e.ovr));
                    end
                end
                pv[k] = cap_valid[k];
                po[k] = cap_overrun[k];
                pd[k] = d;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        en = 1'b1;
        l_dpwm = 4'hF;
        #2;
        do_reset();

        run_to(5);
        chk("pre_rst_ch0", fl(0), 9);
        chk("pre_rst_ch3", fl(3), 9);
        #2;
        do_reset();
        pos();
        chk("resume_p1", fl(0), 1);
        neg();
        chk("resume_n1", fl(0), 2);
        pos();
        chk("resume_p2", fl(0), 3);

        run_to(20);
        l_dpwm[0] = 1'b0;
        push(0, 40, 1'b0);
        pos();
        chk("fall_flags0", fl(0), 20);
        neg();
        chk("restart_n0", fl(0), 0);
        pos();
        chk("restart_p0", fl(0), 1);
        l_dpwm[0] = 1'b1;
        cap_ack = 4'b0001;
        pos();
        cap_ack = '0;
        chk("ack_clear0", int'(cap_valid[0]), 0);

        run_to(29);
        l_dpwm[1] = 1'b0;
        push(1, 58, 1'b0);
        pos();
        l_dpwm[1] = 1'b1;
        run_to(60);
        l_dpwm[1] = 1'b0;
        push(1, 60, 1'b1);
        pos();
        l_dpwm[1] = 1'b1;
        chk("ovr1_set", int'(cap_overrun[1]), 1);
        chk("ovr0_clear", int'(cap_overrun[0]), 0);

        run_to(69);
        l_dpwm[3:2] = 2'b00;
        push(2, 138, 1'b0);
        push(3, 138, 1'b0);
        pos();
        l_dpwm[3:2] = 2'b11;
        run_to(79);
        l_dpwm[2] = 1'b0;
        cap_ack = 4'b1101;
        push(2, 18, 1'b0);
        pos();
        l_dpwm[2] = 1'b1;
        cap_ack = '0;
        chk("samecyc_valid2", int'(cap_valid[2]), 1);
        chk("samecyc_ovr2", int'(cap_overrun[2]), 0);
        chk("ack_valid3", int'(cap_valid[3]), 0);
        chk("idle_ack_valid0", int'(cap_valid[0]), 0);
        chk("ovr1_sticky", int'(cap_overrun[1]), 1);

        run_to(85);
        chk("pre_frz2", fl(2), 9);
        en = 1'b0;
        neg();
        chk("frz_n2", fl(2), 9);
        run_to(87);
        cap_ack = 4'b0100;
        pos();
        cap_ack = '0;
        chk("ack_valid2", int'(cap_valid[2]), 0);
        run_to(95);
        chk("frz_p2", fl(2), 9);
        chk("frz_ch0", fl(0), 127);
        l_dpwm[2] = 1'b0;
        push(2, 9, 1'b0);
        pos();
        l_dpwm[2] = 1'b1;
        chk("frz_fall2", fl(2), 4);
        neg();
        chk("frz_restart2", fl(2), 0);
        pos();
        chk("frz_hold2", fl(2), 0);
        en = 1'b1;
        pos();
        chk("en_resume2", fl(2), 2);

        run_to(102);
        #2;
        do_reset();
        run_to(511);
        chk("p511_ch0", fl(0), 1021);
        neg();
        chk("n511_ch0", fl(0), 1022);
        pos();
`ifdef FLAGS_SATURATE_EN
        chk("p512_ch0", fl(0), 1022);
        run_to(600);
        chk("p600_ch0", fl(0), 1022);
        chk("p600_ch3", fl(3), 1022);
`else
        chk("p512_ch0", fl(0), 511);
        run_to(600);
        chk("p600_ch0", fl(0), 175);
        chk("p600_ch3", fl(3), 175);
`endif
        chk("no_cap_ch0", int'(cap_valid[0]), 0);

        pos();
        pos();
        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
